// File: rtl/siso_pkg.sv
// siso_pkg -- shared definitions for the SISO layer scheduler and the row unit.
//   Default geometry (layers, addresses per layer, bus widths) and the
//   scheduler FSM state encoding.
package siso_pkg;

  localparam int LAYERS_DEF    = 2;
  localparam int ADDRDEPTH_DEF = 20;
  localparam int ADDRWIDTH_DEF = 5;
  localparam int ITERBITS_DEF  = 5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_DRAIN  = 2'd2,
    S_FINISH = 2'd3
  } sched_state_e;

endpackage

// File: rtl/siso_addr_counter.sv
// siso_addr_counter -- layer / row-group address generator.
//   clk, rst        : clock, async active-low reset
//   clr             : return to layer 0, address 0
//   inc_addr        : step address, wrapping to 0 after ADDRDEPTH-1
//   inc_layer       : step layer, wrapping to 0 after LAYERS-1
//   layer_nxt/addr_nxt : values the counters take at the next edge, so the
//                    scheduler can register its read outputs from them
//   addr_last/layer_last : current address / layer is the final one
module siso_addr_counter #(
  parameter int LAYERS    = 2,
  parameter int ADDRDEPTH = 20,
  parameter int ADDRWIDTH = 5,
  parameter int LW        = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc_addr,
  input  logic                 inc_layer,
  output logic [LW-1:0]        layer_nxt,
  output logic [ADDRWIDTH-1:0] addr_nxt,
  output logic                 addr_last,
  output logic                 layer_last
);

  logic [LW-1:0]        layer;
  logic [ADDRWIDTH-1:0] addr;

  assign addr_last  = (addr == ADDRWIDTH'(ADDRDEPTH - 1));
  assign layer_last = (layer == LW'(LAYERS - 1));

  always_comb begin
    layer_nxt = layer;
    addr_nxt  = addr;
    if (clr) begin
      layer_nxt = '0;
      addr_nxt  = '0;
    end else begin
      if (inc_addr)  addr_nxt  = addr_last  ? '0 : addr + ADDRWIDTH'(1);
      if (inc_layer) layer_nxt = layer_last ? '0 : layer + LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      layer <= '0;
      addr  <= '0;
    end else begin
      layer <= layer_nxt;
      addr  <= addr_nxt;
    end
  end

endmodule

// File: rtl/siso_layer_scheduler.sv
// siso_layer_scheduler -- issues layer/address reads to the SISO row unit,
// waits for every address of a layer to be written back, and iterates
// layers until max_iter iterations are done.
//   clk, rst         : clock, async active-low reset
//   start, max_iter  : begin a decode; max_iter latched when start accepted
//   wren             : row-unit write-back strobe, one per retired address
//   rdlayer_regin, rdaddress_regin, rden_LLR_regin : registered read request
//   rden_E           : E-memory read (suppressed in the first iteration)
//   busy, done       : decode in progress / one-cycle completion pulse
//   iter_count       : completed iterations
// Optional build macro SISO_SCHED_EARLY_TERM_EN adds input syndrome_ok,
// which ends the decode at the end of any iteration where it is high.
module siso_layer_scheduler
  import siso_pkg::*;
#(
  parameter int LAYERS    = LAYERS_DEF,
  parameter int ADDRDEPTH = ADDRDEPTH_DEF,
  parameter int ADDRWIDTH = ADDRWIDTH_DEF,
  parameter int ITERBITS  = ITERBITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ITERBITS-1:0]  max_iter,
  input  logic                 wren,
`ifdef SISO_SCHED_EARLY_TERM_EN
  input  logic                 syndrome_ok,
`endif
  output logic                 rdlayer_regin,
  output logic [ADDRWIDTH-1:0] rdaddress_regin,
  output logic                 rden_LLR_regin,
  output logic                 rden_E,
  output logic                 busy,
  output logic                 done,
  output logic [ITERBITS-1:0]  iter_count
);

  localparam int LW = (LAYERS > 1) ? $clog2(LAYERS) : 1;
  localparam int RW = $clog2(ADDRDEPTH + 1);

  sched_state_e         state, state_nxt;
  logic [ITERBITS-1:0]  iter_nxt, max_q, max_nxt;
  logic [ITERBITS:0]    iter_inc;
  logic [RW-1:0]        ret, ret_nxt, ret_sum;
  logic                 clr, inc_addr, inc_layer;
  logic [LW-1:0]        layer_nxt;
  logic [ADDRWIDTH-1:0] addr_nxt;
  logic                 addr_last, layer_last;
  logic                 drain_done, term, issue_nxt;

`ifdef SISO_SCHED_EARLY_TERM_EN
  assign term = syndrome_ok;
`else
  assign term = 1'b0;
`endif

  siso_addr_counter #(
    .LAYERS   (LAYERS),
    .ADDRDEPTH(ADDRDEPTH),
    .ADDRWIDTH(ADDRWIDTH),
    .LW       (LW)
  ) u_addr (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .inc_addr  (inc_addr),
    .inc_layer (inc_layer),
    .layer_nxt (layer_nxt),
    .addr_nxt  (addr_nxt),
    .addr_last (addr_last),
    .layer_last(layer_last)
  );

  // A write-back arriving in the same cycle the count hits the limit
  // still releases DRAIN, hence the compare on the incremented value.
  assign ret_sum    = ret + RW'(wren);
  assign drain_done = (ret_sum >= RW'(ADDRDEPTH));
  // One extra bit so the "below max_iter" compare cannot wrap.
  assign iter_inc   = {1'b0, iter_count} + (ITERBITS + 1)'(1);

  always_comb begin
    state_nxt = state;
    iter_nxt  = iter_count;
    max_nxt   = max_q;
    ret_nxt   = '0;
    clr       = 1'b0;
    inc_addr  = 1'b0;
    inc_layer = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          max_nxt   = max_iter;
          iter_nxt  = '0;
          clr       = 1'b1;
          state_nxt = (max_iter != '0) ? S_ISSUE : S_FINISH;
        end
      end
      S_ISSUE: begin
        inc_addr = 1'b1;
        ret_nxt  = ret_sum;
        if (addr_last) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        ret_nxt = ret_sum;
        if (drain_done) begin
          ret_nxt   = '0;
          inc_layer = 1'b1;
          if (!layer_last) begin
            state_nxt = S_ISSUE;
          end else begin
            iter_nxt  = iter_inc[ITERBITS-1:0];
            state_nxt = (iter_inc < {1'b0, max_q} && !term) ? S_ISSUE : S_FINISH;
          end
        end
      end
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign issue_nxt = (state_nxt == S_ISSUE);

  // Outputs are flopped from next-state values so the first read lands
  // on the cycle right after start is sampled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= S_IDLE;
      iter_count      <= '0;
      max_q           <= '0;
      ret             <= '0;
      rdlayer_regin   <= 1'b0;
      rdaddress_regin <= '0;
      rden_LLR_regin  <= 1'b0;
      rden_E          <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      state           <= state_nxt;
      iter_count      <= iter_nxt;
      max_q           <= max_nxt;
      ret             <= ret_nxt;
      rdlayer_regin   <= issue_nxt & layer_nxt[0];
      rdaddress_regin <= issue_nxt ? addr_nxt : '0;
      rden_LLR_regin  <= issue_nxt;
      rden_E          <= issue_nxt && (iter_nxt != '0);
      busy            <= issue_nxt || (state_nxt == S_DRAIN);
      done            <= (state_nxt == S_FINISH);
    end
  end

endmodule

// File: tb/tb_siso_layer_scheduler.sv
// tb_siso_layer_scheduler -- randomized self-checking bench. A row-unit
// model echoes wren a fixed delay after each observed read; the expected
// read stream is built from nested iteration/layer/address loops.
// Build with +define+SISO_SCHED_EARLY_TERM_EN to add the early-stop case.
module tb_siso_layer_scheduler;

  localparam int LAYERS = 2;
  localparam int DEPTH  = 20;
  localparam int AW     = 5;
  localparam int IB     = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [IB-1:0] max_iter = '0;
  logic          wren = 1'b0;
`ifdef SISO_SCHED_EARLY_TERM_EN
  logic          syndrome_ok = 1'b0;
`endif
  logic          rdlayer_regin;
  logic [AW-1:0] rdaddress_regin;
  logic          rden_LLR_regin, rden_E, busy, done;
  logic [IB-1:0] iter_count;

  siso_layer_scheduler #(
    .LAYERS(LAYERS), .ADDRDEPTH(DEPTH), .ADDRWIDTH(AW), .ITERBITS(IB)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .max_iter       (max_iter),
    .wren           (wren),
`ifdef SISO_SCHED_EARLY_TERM_EN
    .syndrome_ok    (syndrome_ok),
`endif
    .rdlayer_regin  (rdlayer_regin),
    .rdaddress_regin(rdaddress_regin),
    .rden_LLR_regin (rden_LLR_regin),
    .rden_E         (rden_E),
    .busy           (busy),
    .done           (done),
    .iter_count     (iter_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int layer;
    int addr;
    bit e;
    bit bsy;
    int cyc;
  } rd_t;

  rd_t obs[$];
  int  due[$];
  int  cyc = 0;
  int  done_cnt = 0;
  int  done_cyc = -1;
  bit  busy_at_done = 1'b0;
  int  echo_d = 13;
  int  hold_idx = -1;
  int  held_due = -1;
  int  hold_wren_cyc = -1;
  bit  noise = 1'b0;

  // Row-unit model and output monitor; everything happens at negedge.
  always @(negedge clk) begin
    cyc++;
    if (rden_LLR_regin) begin
      obs.push_back('{int'(rdlayer_regin), int'(rdaddress_regin), rden_E, busy, cyc});
      if (obs.size() - 1 == hold_idx) begin
        held_due = cyc + echo_d + 50;
        due.push_back(held_due);
      end else begin
        due.push_back(cyc + echo_d);
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = busy;
    end
    wren = noise;
    if (due.size() > 0 && due[0] <= cyc) begin
      wren = 1'b1;
      if (due[0] == held_due) hold_wren_cyc = cyc;
      void'(due.pop_front());
    end
  end

  // One decode from start to done, then checks against the loop model.
  task automatic run(input int mi, input int d, input bit hold,
                     input bit disturb, input int term, input string tag);
    int s, n_it, exp_n, bad, idx, gap;
    obs.delete();
    done_cnt = 0; done_cyc = -1; echo_d = d;
    hold_idx = hold ? DEPTH - 1 : -1;
    held_due = -1; hold_wren_cyc = -1;
    @(negedge clk);
    start = 1'b1; max_iter = IB'(mi);
    #1 s = cyc;
    @(negedge clk);
    start = 1'b0; max_iter = IB'($urandom);
    for (int k = 0; k < 20000 && done_cnt == 0; k++) begin
      @(negedge clk); #1;
      start = disturb && busy && ($urandom_range(0, 3) == 0);
`ifdef SISO_SCHED_EARLY_TERM_EN
      syndrome_ok = (term > 0) && (obs.size() >= term * LAYERS * DEPTH);
`endif
    end
    start = 1'b0;
`ifdef SISO_SCHED_EARLY_TERM_EN
    syndrome_ok = 1'b0;
`endif
    repeat (6) @(negedge clk);
    #1;
    n_it  = (term > 0 && term < mi) ? term : mi;
    exp_n = n_it * LAYERS * DEPTH;
    bad = 0; idx = 0;
    for (int it = 0; it < n_it; it++)
      for (int l = 0; l < LAYERS; l++)
        for (int a = 0; a < DEPTH; a++) begin
          if (idx < obs.size())
            if (obs[idx].layer != l || obs[idx].addr != a ||
                obs[idx].e != (it != 0) || !obs[idx].bsy) bad++;
          idx++;
        end
    chk({tag, "_nreads"}, obs.size(), exp_n);
    chk({tag, "_seq"}, bad, 0);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_iter"}, iter_count, n_it);
    chk({tag, "_busy_done"}, busy_at_done, 0);
    if (exp_n > 0) begin
      if (obs.size() > 0) chk({tag, "_first_cyc"}, obs[0].cyc, s + 1);
      else chk({tag, "_first_cyc"}, -1, s + 1);
    end else begin
      chk({tag, "_done_cyc"}, done_cyc, s + 1);
    end
    if (hold) begin
      if (obs.size() > DEPTH) begin
        gap = obs[DEPTH].cyc - obs[DEPTH - 1].cyc;
        chk({tag, "_drain_hold"}, gap >= 50, 1);
        chk({tag, "_l1_after_wren"}, obs[DEPTH].cyc - hold_wren_cyc, 1);
      end else begin
        chk({tag, "_drain_hold"}, obs.size(), DEPTH + 1);
      end
    end
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_rden"}, rden_LLR_regin, 0);
    chk({tag, "_rdenE"}, rden_E, 0);
    chk({tag, "_addr"}, rdaddress_regin, 0);
    chk({tag, "_layer"}, rdlayer_regin, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_iter"}, iter_count, 0);
  endtask

  initial begin
    int k;
    // Reset state.
    #12 chk_outs_zero("reset");
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);

    // Baseline: two iterations, 13-cycle echo.
    run(2, 13, 1'b0, 1'b0, 0, "base");

    // Zero iterations: straight to done, no reads.
    run(0, 13, 1'b0, 1'b0, 0, "zero");

    // Stray write-backs while idle must not count.
    @(negedge clk); noise = 1'b1;
    repeat (3) @(negedge clk);
    noise = 1'b0;

    // Last write-back of layer 0 held back by 50 cycles.
    run(2, 13, 1'b1, 1'b0, 0, "hold");

    // Start pulses during the decode are ignored.
    run(2, $urandom_range(1, 20), 1'b0, 1'b1, 0, "dist");

    // Reset in the middle of layer 0 at address 7.
    obs.delete(); done_cnt = 0; echo_d = 13; hold_idx = -1;
    @(negedge clk); start = 1'b1; max_iter = IB'(2);
    @(negedge clk); start = 1'b0;
    k = 0;
    while (!(obs.size() > 0 && obs[obs.size() - 1].addr == 7) && k < 100) begin
      @(negedge clk); #1; k++;
    end
    chk("rst_reach_addr7", k < 100, 1);
    #2 rst = 1'b0;
    #1 chk_outs_zero("rst_mid");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);  // pending write-backs arrive while idle
    chk("rst_no_done", done_cnt, 0);
    run(2, $urandom_range(1, 20), 1'b0, 1'b0, 0, "restart");

    // Randomized decodes.
    for (int r = 0; r < 3; r++)
      run($urandom_range(1, 3), $urandom_range(1, 20), 1'b0,
          1'($urandom_range(0, 1)), 0, "rand");

`ifdef SISO_SCHED_EARLY_TERM_EN
    run(10, 13, 1'b0, 1'b0, 3, "early");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/siso_layer_scheduler.md
SISO_LAYER_SCHEDULER -- requirements
Module: siso_layer_scheduler

Interface
REQ-001 Parameter LAYERS, default 2, number of layers per iteration.
REQ-002 Parameter ADDRDEPTH, default 20, row-group addresses per layer.
REQ-003 Parameter ADDRWIDTH, default 5, address bus width.
REQ-004 Parameter ITERBITS, default 5, width of iteration count.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle request to begin a decode.
REQ-008 max_iter  input  ITERBITS  iteration limit, sampled on accepted start.
REQ-009 wren  input  1  row-unit write-back strobe, one per retired address.
REQ-010 rdlayer_regin  output  1  layer index issued to the row unit.
REQ-011 rdaddress_regin  output  ADDRWIDTH  address issued to the row unit.
REQ-012 rden_LLR_regin  output  1  LLR read / row-unit valid.
REQ-013 rden_E  output  1  E-memory read enable.
REQ-014 busy  output  1  high from accepted start until done.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 iter_count  output  ITERBITS  completed iterations.

Function
REQ-017 FSM states IDLE, ISSUE, DRAIN, FINISH; IDLE is the reset state.
REQ-018 IDLE: start=1 and max_iter!=0 -> ISSUE with layer=0, addr=0, iter_count=0, busy=1 next cycle.
REQ-019 IDLE: start=1 and max_iter=0 -> FINISH directly; no read is issued.
REQ-020 ISSUE: rden_LLR_regin=1 every cycle, with rdlayer_regin=layer and rdaddress_regin=addr; addr increments by 1 per cycle.
REQ-021 ISSUE: addr=ADDRDEPTH-1 -> DRAIN next cycle and addr wraps to 0; no bubble inside a layer.
REQ-022 rden_E=rden_LLR_regin AND (iter_count!=0); on the first iteration E memory is not read.
REQ-023 Retire counter increments on each wren=1 and clears on DRAIN exit; wren pulses in IDLE or FINISH are ignored.
REQ-024 DRAIN: read outputs are 0; remain until retire count equals ADDRDEPTH, including a wren arriving in the same cycle the count reaches the limit.
REQ-025 DRAIN exit, layer<LAYERS-1 -> ISSUE with layer+1.
REQ-026 DRAIN exit, layer=LAYERS-1 -> iter_count+1 and layer=0; then ISSUE if the new count is below max_iter, else FINISH.
REQ-027 FINISH: done=1 for exactly one cycle, busy=0 and iter_count held; next state IDLE.
REQ-028 start while busy=1 is ignored and has no side effect.
REQ-029 max_iter is latched on start; changes during a decode have no effect.
REQ-030 All outputs are registered; the first read appears on the cycle after start is sampled.

Reset
REQ-031 While rst=0: state=IDLE; busy, done, rden_LLR_regin, rden_E, rdlayer_regin, rdaddress_regin, iter_count and the retire counter are all 0.
REQ-032 Reset mid-operation aborts immediately; no done pulse is produced; later wren pulses are ignored until the next start.

Configuration
REQ-033 Macro SISO_SCHED_EARLY_TERM_EN: when defined, add input syndrome_ok (1 bit).
REQ-034 With SISO_SCHED_EARLY_TERM_EN: on DRAIN exit at layer=LAYERS-1, syndrome_ok=1 forces FINISH regardless of max_iter; iter_count still increments.
REQ-035 Without the macro: the port is absent and only max_iter terminates a decode.

Structure
REQ-036 Package siso_pkg holds the FSM state enum and the LAYERS, ADDRDEPTH, ADDRWIDTH and ITERBITS defaults shared with the row unit.
REQ-037 One sub-module, siso_addr_counter, provides layer/address generation with wrap and a last flag.

Verification
REQ-038 start, max_iter=2, wren echoed 13 cycles after each read -> 80 reads (20 per layer, 2 layers, 2 iterations), rden_E=0 for the first 40 reads and 1 for the last 40, done once, iter_count=2.
REQ-039 start with max_iter=0 -> done on the second cycle, no rden_LLR_regin, iter_count=0.
REQ-040 Hold back the last wren of layer 0 for 50 cycles -> scheduler stays in DRAIN with reads low; layer 1 begins the cycle after that wren.
REQ-041 start pulsed during ISSUE -> read sequence and counts identical to an undisturbed run.
REQ-042 rst dropped mid-layer at addr=7 -> all outputs 0 asynchronously, no done pulse; a new start restarts at layer 0, addr 0.
REQ-043 With SISO_SCHED_EARLY_TERM_EN, max_iter=10, syndrome_ok=1 at end of iteration 3 -> done, iter_count=3.
